debug_snapshot_tx: RTL
======================

Name: debug_snapshot_tx

Overview:
Reader and transmitter for the pipeline's debug observation buses: the program counter, the register file (1024 bits) and the data memory (320 bits).
- On a trigger it takes an atomic snapshot of those buses and streams it as a framed byte sequence over a valid/ready byte interface.
- The byte stream feeds the board UART transmitter.
- It sits beside the Pipeline top level and consumes the same debug outputs the simulation bench inspects.

Parameters:
PC_BITS, 10, width of pc_in; zero-padded to 16 bits in the frame.
REG_BITS, 1024, width of registers_in (32 x 32-bit registers); must be a multiple of 8.
MEM_BITS, 320, width of memorias_in (10 x 32-bit words); must be a multiple of 8.
HEADER, 8'hA5, frame start byte.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
trigger  in  1  request a snapshot; sampled on the rising edge.
pc_in  in  PC_BITS  current PC from the pipeline.
registers_in  in  REG_BITS  flattened register file; register 0 is in bits [31:0].
memorias_in  in  MEM_BITS  flattened data memory; word 0 is in bits [31:0].
tx_data  out  8  byte offered to the UART transmitter.
tx_valid  out  1  tx_data holds a valid byte.
tx_ready  in  1  UART transmitter accepts the byte.
busy  out  1  a frame is in progress (capture through the checksum byte).
done  out  1  one-cycle pulse after the checksum byte is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; tx_data=0, tx_valid=0, busy=0, done=0.
  - Byte counter, checksum and shadow register cleared.
- Frame layout, 172 bytes, in this order:
  - HEADER.
  - PC low byte, then PC high byte (bits above PC_BITS are 0).
  - REG_BITS/8 = 128 register bytes, from bits [7:0] upward.
  - MEM_BITS/8 = 40 memory bytes, from bits [7:0] upward.
  - CHK = XOR of all 171 preceding bytes, header included.
- Transfer rule: a byte is transferred on a rising edge where tx_valid=1 and tx_ready=1.
- While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable; tx_valid never drops without a transfer.
- tx_ready is ignored while tx_valid=0.
- FSM states: IDLE, SEND, CHK, DONE.
- IDLE:
  - trigger=1 at edge N loads the shadow shift register {memorias_in, registers_in, pc16, HEADER} (HEADER in the LSBs).
  - At the same edge, counter=0 and checksum=0; go to SEND.
  - busy and tx_valid are 1 from cycle N+1, with tx_data=HEADER.
- SEND:
  - tx_data = shadow[7:0].
  - On each transfer: checksum ^= tx_data, shadow shifts right by 8, counter increments.
  - The transfer at counter=170 goes to CHK.
- CHK:
  - tx_data = checksum; tx_valid=1.
  - On transfer: tx_valid=0, go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
  - A trigger seen in DONE is ignored.
- Trigger while busy or in DONE is ignored: no queueing, snapshot not modified.
- Inputs may change freely after the capture edge; the frame reflects only the capture-edge values.
- Back-to-back: a trigger in the first IDLE cycle after DONE starts a new frame. Minimum gap between frames is 2 idle cycles with tx_valid=0.
- Reset mid-frame aborts immediately: tx_valid=0, no done pulse, no partial checksum emitted.
- Throughput: one byte per cycle when tx_ready is held at 1.
  - Frame occupies 172 transfer cycles.
  - done asserts the cycle after the last transfer.
- Counter is 8 bits, sized for 171; no wrap occurs within a frame.

Decomposition:
- Shared package holds: FRAME_HDR=8'hA5, PAYLOAD_BYTES = 3 + REG_BITS/8 + MEM_BITS/8 = 171, FRAME_BYTES=172, and the FSM state encoding (2 bits: IDLE=0, SEND=1, CHK=2, DONE=3).
- One sub-module is natural: snapshot_shifter.
  - Loads 1368 bits on capture.
  - Shifts out 8 bits on each advance.
  - Exposes the current byte.
  - The FSM, counter and checksum remain in debug_snapshot_tx.

Test Plan:
1. Basic frame:
   - Stimulus: pc_in=10'h004, registers_in=0, memorias_in=0, tx_ready=1, trigger pulse.
   - Response: bytes A5,04,00, then 168 x 00, then checksum A1; done pulse one cycle after A1; busy high for exactly 173 cycles.
2. Data ordering:
   - Stimulus: register 1 = 32'h11223344, memory word 9 = 32'hDEADBEEF, pc=10'h3FF.
   - Response: PC bytes FF,03; register bytes 7-10 are 44,33,22,11; last 4 memory bytes are EF,BE,AD,DE; checksum equals the XOR computed by the bench model.
3. Backpressure:
   - Stimulus: tx_ready toggled with pattern 1,0,0,1 throughout the frame.
   - Response: tx_data/tx_valid stable in every stalled cycle; the byte sequence is identical to scenario 2; no byte dropped or duplicated.
4. Trigger while busy plus snapshot isolation:
   - Stimulus: second trigger at byte 50; all inputs changed after capture.
   - Response: frame contents unchanged; exactly one done pulse; no second frame starts.
5. Reset mid-frame:
   - Stimulus: reset=0 for one cycle at byte 80, then a new trigger.
   - Response: tx_valid/busy/done are 0 immediately; no done pulse; the new frame starts with A5 and a fresh checksum.
6. Back-to-back:
   - Stimulus: trigger held high continuously with tx_ready=1.
   - Response: consecutive frames of 172 bytes each, separated by exactly 2 cycles with tx_valid=0 (DONE cycle, then the IDLE capture cycle).

Source files
------------

// File: rtl/debug_snapshot_tx_pkg.sv
// rtl/debug_snapshot_tx_pkg.sv - shared constants, frame sizing and FSM encoding for the debug snapshot transmitter
package debug_snapshot_tx_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  // Bytes before the checksum: header, two PC bytes, register bytes, memory bytes.
  function automatic int payload_bytes(input int reg_bits, input int mem_bits);
    return 3 + reg_bits / 8 + mem_bits / 8;
  endfunction

  localparam int PAYLOAD_BYTES = payload_bytes(1024, 320);
  localparam int FRAME_BYTES   = PAYLOAD_BYTES + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/snapshot_shifter.sv
// rtl/snapshot_shifter.sv - shadow register holding the captured frame, shifted out one byte per advance
module snapshot_shifter #(
  parameter int WIDTH = 1368
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             advance,
  output logic [7:0]       byte_out
);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;

  // Capture takes priority; otherwise drop the byte just sent off the bottom.
  always_comb begin
    shadow_d = shadow_q;
    if (load) begin
      shadow_d = load_data;
    end else if (advance) begin
      shadow_d = shadow_q >> 8;
    end
  end

  // Shadow storage, cleared on reset so nothing stale is ever presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign byte_out = shadow_q[7:0];

endmodule

// File: rtl/debug_snapshot_tx.sv
// rtl/debug_snapshot_tx.sv - snapshots PC/register/memory debug buses and streams them as a checksummed byte frame
module debug_snapshot_tx
  import debug_snapshot_tx_pkg::*;
#(
  parameter int         PC_BITS  = 10,
  parameter int         REG_BITS = 1024,
  parameter int         MEM_BITS = 320,
  parameter logic [7:0] HEADER   = FRAME_HDR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trigger,
  input  logic [PC_BITS-1:0]  pc_in,
  input  logic [REG_BITS-1:0] registers_in,
  input  logic [MEM_BITS-1:0] memorias_in,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done
);

  localparam int         SHADOW_BITS = MEM_BITS + REG_BITS + 24;
  localparam int         NBYTES      = payload_bytes(REG_BITS, MEM_BITS);
  localparam logic [7:0] LAST_IDX    = 8'(NBYTES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] chk_q, chk_d;

  logic [15:0]            pc16;
  logic [SHADOW_BITS-1:0] load_data;
  logic                   load;
  logic                   advance;
  logic [7:0]             shift_byte;

  assign pc16      = 16'(pc_in);
  assign load_data = {memorias_in, registers_in, pc16, HEADER};

  snapshot_shifter #(
    .WIDTH(SHADOW_BITS)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (reset),
    .load     (load),
    .load_data(load_data),
    .advance  (advance),
    .byte_out (shift_byte)
  );

  // Next-state, byte counter and running checksum; a byte moves only when valid meets ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          load    = 1'b1;
          cnt_d   = 8'd0;
          chk_d   = 8'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          advance = 1'b1;
          chk_d   = chk_q ^ shift_byte;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == LAST_IDX) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (tx_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; busy also covers the capture cycle, gated so reset forces it low.
  always_comb begin
    tx_data  = 8'd0;
    tx_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: busy = trigger & reset;
      ST_SEND: begin
        tx_data  = shift_byte;
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      ST_CHK: begin
        tx_data  = chk_q;
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  // State, counter and checksum registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      chk_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
    end
  end

endmodule
